// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - in-order register writeback FIFO with bank write port and youngest-value forwarding
// Optional: WBQ_COALESCE_EN merges a push into the tail entry when the destination register matches.
module reg_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     wb_stall,
  output logic                     RegWrite,
  output logic [AW-1:0]            AWrite,
  output logic [DW-1:0]            DataIn,
  input  logic [AW-1:0]            AR1,
  input  logic [AW-1:0]            AR2,
  output logic                     fwd1_hit,
  output logic [DW-1:0]            fwd1_data,
  output logic                     fwd2_hit,
  output logic [DW-1:0]            fwd2_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   ONE_CNT  = (PW+1)'(1);
  localparam logic [PW-1:0] ONE_PTR  = PW'(1);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          regwrite_q;
  logic [AW-1:0] awrite_q;
  logic [DW-1:0] datain_q;

  logic full, pop, coalesce, push_acc, store;

  assign full = (count_q == FULL_CNT);
  assign pop  = (count_q != '0) && !wb_stall;

`ifdef WBQ_COALESCE_EN
  logic [PW-1:0] tail_idx;
  assign tail_idx = wr_ptr_q - ONE_PTR;
  // Never merge into the entry that is leaving this cycle; it would be lost.
  assign coalesce = (count_q != '0) && (addr_q[tail_idx] == in_addr) && (in_addr != '0)
                    && !(pop && count_q == ONE_CNT);
  assign in_ready = !full || coalesce;
`else
  assign coalesce = 1'b0;
  assign in_ready = !full;
`endif

  assign push_acc = in_valid && in_ready && (in_addr != '0);
  assign store    = push_acc && !coalesce;

  always_comb begin
    count_d = count_q;
    case ({store, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      awrite_q   <= '0;
      datain_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (store) begin
        addr_q[wr_ptr_q] <= in_addr;
        data_q[wr_ptr_q] <= in_data;
        wr_ptr_q         <= wr_ptr_q + ONE_PTR;
      end
`ifdef WBQ_COALESCE_EN
      else if (push_acc) begin
        data_q[tail_idx] <= in_data;
      end
`endif
      if (pop) begin
        regwrite_q <= 1'b1;
        awrite_q   <= addr_q[rd_ptr_q];
        datain_q   <= data_q[rd_ptr_q];
        rd_ptr_q   <= rd_ptr_q + ONE_PTR;
      end else begin
        regwrite_q <= 1'b0;
      end
    end
  end

  // Walk oldest to youngest so later matches override; the output stage is lowest priority.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    if (regwrite_q && awrite_q == AR1 && AR1 != '0) begin
      fwd1_hit  = 1'b1;
      fwd1_data = datain_q;
    end
    if (regwrite_q && awrite_q == AR2 && AR2 != '0) begin
      fwd2_hit  = 1'b1;
      fwd2_data = datain_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((PW+1)'(i) < count_q) begin
        if (addr_q[rd_ptr_q + PW'(i)] == AR1 && AR1 != '0) begin
          fwd1_hit  = 1'b1;
          fwd1_data = data_q[rd_ptr_q + PW'(i)];
        end
        if (addr_q[rd_ptr_q + PW'(i)] == AR2 && AR2 != '0) begin
          fwd2_hit  = 1'b1;
          fwd2_data = data_q[rd_ptr_q + PW'(i)];
        end
      end
    end
  end

  assign RegWrite = regwrite_q;
  assign AWrite   = awrite_q;
  assign DataIn   = datain_q;
  assign count    = count_q;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb/tb_reg_writeback_queue.sv - self-checking bench for reg_writeback_queue against a queue model
module tb_reg_writeback_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic          wb_stall = 1'b0;
  logic          RegWrite;
  logic [AW-1:0] AWrite;
  logic [DW-1:0] DataIn;
  logic [AW-1:0] AR1 = '0;
  logic [AW-1:0] AR2 = '0;
  logic          fwd1_hit, fwd2_hit;
  logic [DW-1:0] fwd1_data, fwd2_data;
  logic [2:0]    count;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  chk_en   = 0;

  always #5 clk = ~clk;

  reg_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .wb_stall(wb_stall),
    .RegWrite(RegWrite), .AWrite(AWrite), .DataIn(DataIn),
    .AR1(AR1), .AR2(AR2), .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data), .count(count)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  bit            m_rw = 0;
  logic [AW-1:0] m_aw = '0;
  logic [DW-1:0] m_di = '0;

  function automatic bit model_coal();
    int n = q.size();
    bit pop = (n != 0) && !wb_stall;
`ifdef WBQ_COALESCE_EN
    return (n != 0) && (q[n-1].a == in_addr) && (in_addr != 0) && !(pop && n == 1);
`else
    return pop && 1'b0;
`endif
  endfunction

  function automatic bit model_ready();
    return (q.size() < DEPTH) || model_coal();
  endfunction

  function automatic void model_fwd(input logic [AW-1:0] ar, output bit hit, output logic [DW-1:0] d);
    hit = 0;
    d   = '0;
    if (ar == 0) return;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].a == ar) begin
        hit = 1;
        d   = q[i].d;
        return;
      end
    end
    if (m_rw && m_aw == ar) begin
      hit = 1;
      d   = m_di;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    bit pop, rdy, coal;
    ent_t e;
    if (rst) begin
      q.delete();
      m_rw = 0;
      m_aw = '0;
      m_di = '0;
    end else begin
      pop  = (q.size() != 0) && !wb_stall;
      coal = model_coal();
      rdy  = model_ready();
      if (pop) begin
        m_rw = 1;
        m_aw = q[0].a;
        m_di = q[0].d;
        void'(q.pop_front());
      end else begin
        m_rw = 0;
      end
      if (in_valid && rdy && in_addr != 0) begin
        if (coal) q[q.size()-1].d = in_data;
        else begin
          e.a = in_addr;
          e.d = in_data;
          q.push_back(e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit h1, h2;
    logic [DW-1:0] d1, d2;
    if (chk_en) begin
      model_fwd(AR1, h1, d1);
      model_fwd(AR2, h2, d2);
      check("in_ready", in_ready, model_ready());
      check("count", count, q.size());
      check("RegWrite", RegWrite, m_rw);
      check("AWrite", AWrite, m_aw);
      check("DataIn", DataIn, m_di);
      check("fwd1_hit", fwd1_hit, h1);
      check("fwd1_data", fwd1_data, d1);
      check("fwd2_hit", fwd2_hit, h2);
      check("fwd2_data", fwd2_data, d2);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_valid = 1;
    in_addr  = a;
    in_data  = d;
    cyc();
    in_valid = 0;
  endtask

  initial begin
    int writes;
    #2 rst = 1;
    chk_en = 1;
    cyc();
    cyc();
    rst = 0;

    // 1: idle after reset
    AR1 = 3;
    AR2 = 0;
    repeat (5) cyc();
    check("t1_regwrite", RegWrite, 0);
    check("t1_count", count, 0);
    check("t1_in_ready", in_ready, 1);
    check("t1_fwd1_hit", fwd1_hit, 0);
    check("t1_fwd2_hit", fwd2_hit, 0);

    // 2: two stalled pushes drain in order
    wb_stall = 1;
    push(3, 32'hAAAA0001);
    push(7, 32'h12345678);
    check("t2_count", count, 2);
    wb_stall = 0;
    cyc();
    check("t2_w1_rw", RegWrite, 1);
    check("t2_w1_aw", AWrite, 3);
    check("t2_w1_di", DataIn, 32'hAAAA0001);
    cyc();
    check("t2_w2_rw", RegWrite, 1);
    check("t2_w2_aw", AWrite, 7);
    check("t2_w2_di", DataIn, 32'h12345678);
    cyc();
    check("t2_idle_rw", RegWrite, 0);

    // 3: fill, refused fifth push, drain exactly four
    wb_stall = 1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + i);
    check("t3_in_ready", in_ready, 0);
    check("t3_count_full", count, 4);
    push(10, 32'hDEAD);
    check("t3_count_after5", count, 4);
    wb_stall = 0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check("t3_rw", RegWrite, 1);
      check("t3_aw", AWrite, i);
      check("t3_di", DataIn, 32'h100 + i);
    end
    cyc();
    check("t3_done_rw", RegWrite, 0);

    // 4: forwarding picks the youngest value
    wb_stall = 1;
    push(5, 1);
    push(5, 2);
    AR1 = 5;
    AR2 = 0;
    #1;
    check("t4_fwd1_hit", fwd1_hit, 1);
    check("t4_fwd1_data", fwd1_data, 2);
    check("t4_fwd2_hit", fwd2_hit, 0);
    wb_stall = 0;
    repeat (3) cyc();
    // push in flight is invisible until the next cycle, then visible from the output stage
    wb_stall = 1;
    AR1 = 6;
    in_valid = 1;
    in_addr  = 6;
    in_data  = 77;
    #1;
    check("t4_inflight_hit", fwd1_hit, 0);
    cyc();
    in_valid = 0;
    check("t4_queued_hit", fwd1_hit, 1);
    check("t4_queued_data", fwd1_data, 77);
    wb_stall = 0;
    cyc();
    check("t4_outstage_hit", fwd1_hit, 1);
    check("t4_outstage_data", fwd1_data, 77);
    cyc();
    check("t4_retired_hit", fwd1_hit, 0);

    // 5: r0 dropped; reset mid-drain
    push(0, 32'hFFFFFFFF);
    check("t5_r0_count", count, 0);
    cyc();
    check("t5_r0_rw", RegWrite, 0);
    wb_stall = 1;
    for (int i = 1; i <= 4; i++) push(5'(i + 10), i);
    wb_stall = 0;
    cyc();
    wb_stall = 1;
    check("t5_pre_count", count, 3);
    check("t5_pre_rw", RegWrite, 1);
    rst = 1;
    #1;
    check("t5_rst_count", count, 0);
    check("t5_rst_rw", RegWrite, 0);
    check("t5_rst_ready", in_ready, 1);
    cyc();
    rst = 0;
    wb_stall = 0;
    cyc();

    // 6: same-register pushes, merged only with coalescing enabled
    wb_stall = 1;
    push(9, 1);
    push(9, 2);
`ifdef WBQ_COALESCE_EN
    check("t6_count", count, 1);
`else
    check("t6_count", count, 2);
`endif
    wb_stall = 0;
    writes = 0;
    repeat (4) begin
      cyc();
      if (RegWrite) writes++;
    end
`ifdef WBQ_COALESCE_EN
    check("t6_writes", writes, 1);
`else
    check("t6_writes", writes, 2);
`endif
    check("t6_last_aw", AWrite, 9);
    check("t6_last_di", DataIn, 2);

    // randomized traffic, heavy stall then light stall
    for (int c = 0; c < 3000; c++) begin
      in_valid = $urandom_range(0, 1);
      in_addr  = 5'($urandom_range(0, 7));
      in_data  = $urandom;
      wb_stall = (c < 1500) ? ($urandom_range(0, 7) < 5) : ($urandom_range(0, 7) < 2);
      AR1      = 5'($urandom_range(0, 7));
      AR2      = 5'($urandom_range(0, 7));
      rst      = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 0;
    in_valid = 0;
    cyc();
    chk_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
